// File: rtl/byte_lane_dmem.sv
// Byte-lane RV32I data memory: lb/lh/lw/lbu/lhu and sb/sh/sw behind a one-outstanding handshake.
// Define DMEM_MISALIGN_SPLIT_EN to allow misaligned accesses, splitting word-crossing ones over two words.
module byte_lane_dmem #(
    parameter int DEPTH = 512
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, SECOND, RESP} state_e;

    function automatic logic [2:0] size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Lanes and data are laid out over an 8-byte window: [3:0] first word, [7:4] second word.
    function automatic logic [7:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
        logic [7:0] m;
        case (f3[1:0])
            2'b00:   m = 8'h01;
            2'b01:   m = 8'h03;
            default: m = 8'h0F;
        endcase
        return m << off;
    endfunction

    function automatic logic [63:0] lane_data(input logic [31:0] wd, input logic [1:0] off);
        return {32'd0, wd} << {off, 3'b000};
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [63:0] win);
        logic [31:0] sh;
        sh = 32'(win >> {off, 3'b000});
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b100:  return {24'd0, sh[7:0]};
            3'b101:  return {16'd0, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    state_e         state_q, state_d;
    logic           err_q, err_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           we_q;
    logic [2:0]     f3_q;
    logic [1:0]     off_q;
    logic [31:0]    wdata_q;
    logic [AW-1:0]  w1_q;
    logic [31:0]    lo_q;

    logic [31:0]    mem_q [DEPTH];

    logic           accept;
    logic [1:0]     a_off;
    logic [29:0]    a_word;
    logic [2:0]     a_size;
    logic           a_f3_ok;
    logic           a_align_err;
    logic           a_split;
    logic           a_range_err;
    logic           a_err;
    logic [30:0]    a_w0;
    logic [30:0]    a_w1;
    logic [7:0]     a_be;
    logic [63:0]    a_data;
    logic [7:0]     q_be;
    logic [63:0]    q_data;
    logic [31:0]    rd_word;

    logic           wr_en;
    logic [AW-1:0]  wr_idx;
    logic [3:0]     wr_be;
    logic [31:0]    wr_data;

`ifdef DMEM_MISALIGN_SPLIT_EN
    logic [2:0]     a_end;
`endif

    assign req_ready = rst_n && (state_q == IDLE);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = rsp_valid ? rdata_q : 32'd0;

    // Request decode: every error is resolved here, before any byte is written.
    always_comb begin
        a_off  = req_addr[1:0];
        a_word = req_addr[31:2];
        a_size = size_of(req_funct3);
        if (req_we) a_f3_ok = (req_funct3 inside {3'b000, 3'b001, 3'b010});
        else        a_f3_ok = (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
`ifdef DMEM_MISALIGN_SPLIT_EN
        a_end       = {1'b0, a_off} + a_size;
        a_align_err = 1'b0;
        a_split     = (a_end > 3'd4);
`else
        a_align_err = ((a_size == 3'd2) && a_off[0]) || ((a_size == 3'd4) && (a_off != 2'b00));
        a_split     = 1'b0;
`endif
        a_w0        = {1'b0, a_word};
        a_w1        = a_w0 + 31'd1;
        a_range_err = (a_w0 >= 31'(DEPTH)) || (a_split && (a_w1 >= 31'(DEPTH)));
        a_err       = !a_f3_ok || a_align_err || a_range_err;
        a_be        = lane_mask(req_funct3, a_off);
        a_data      = lane_data(req_wdata, a_off);
        q_be        = lane_mask(f3_q, off_q);
        q_data      = lane_data(wdata_q, off_q);
        rd_word     = mem_q[a_word[AW-1:0]];
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case leaves one unassigned (no latches).
        state_d = state_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        wr_en   = 1'b0;
        wr_idx  = '0;
        wr_be   = 4'd0;
        wr_data = 32'd0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RESP;
                    err_d   = a_err;
                    rdata_d = 32'd0;
                    if (!a_err) begin
                        if (a_split) state_d = SECOND;
                        if (req_we) begin
                            wr_en   = 1'b1;
                            wr_idx  = a_word[AW-1:0];
                            wr_be   = a_be[3:0];
                            wr_data = a_data[31:0];
                        end else begin
                            rdata_d = load_extract(req_funct3, a_off, {32'd0, rd_word});
                        end
                    end
                end
            end
            SECOND: begin
                state_d = RESP;
                if (we_q) begin
                    wr_en   = 1'b1;
                    wr_idx  = w1_q;
                    wr_be   = q_be[7:4];
                    wr_data = q_data[63:32];
                end else begin
                    rdata_d = load_extract(f3_q, off_q, {mem_q[w1_q], lo_q});
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            off_q   <= 2'd0;
            wdata_q <= 32'd0;
            w1_q    <= '0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            if (accept) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                off_q   <= a_off;
                wdata_q <= req_wdata;
                w1_q    <= a_word[AW-1:0] + AW'(1);
                lo_q    <= rd_word;
            end
        end
    end

    // NOTE: the storage array is deliberately not reset; contents survive rst_n and map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_byte_lane_dmem.sv
// Self-checking bench for byte_lane_dmem: directed spec scenarios plus random traffic
// against a byte-array reference model; honours DMEM_MISALIGN_SPLIT_EN when defined.
module tb_byte_lane_dmem;
    localparam int DEPTH = 512;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int compared = 0;
    int mismatched = 0;

    logic [7:0] mdl [DEPTH*4];

    always #5 clk = ~clk;

    byte_lane_dmem #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: byte-addressed memory, RV32I width/sign rules, range check over every touched byte.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
        int sz;
        bit ok;
        longint unsigned a;
        logic [31:0] v;
        a  = addr;
        sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        ok = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifndef DMEM_MISALIGN_SPLIT_EN
        if ((a % sz) != 0) ok = 0;
`endif
        if (ok) for (int i = 0; i < sz; i++) if (((a + i) >> 2) >= DEPTH) ok = 0;
        rd  = 32'd0;
        lat = 1;
        er  = !ok;
        if (ok) begin
`ifdef DMEM_MISALIGN_SPLIT_EN
            if ((a % 4) + sz > 4) lat = 2;
`endif
            if (we) begin
                for (int i = 0; i < sz; i++) mdl[a + i] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < sz; i++) v = v | (32'(mdl[a + i]) << (8 * i));
                if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
                if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
                rd = v;
            end
        end
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
        int waited;
        @(negedge clk);
        waited = 0;
        while (!req_ready && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rd  = 'x;
        er  = 1'bx;
        lat = 0;
        while (lat < 6) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) begin
                rd = rsp_rdata;
                er = rsp_err;
                break;
            end
        end
    endtask

    task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input string tag);
        logic [31:0] rd, erd;
        logic er, eer;
        int lat, elat;
        model(we, f3, addr, wd, erd, eer, elat);
        issue(we, f3, addr, wd, rd, er, lat);
        check({tag, ".rdata"}, rd, erd);
        check({tag, ".err"}, {31'd0, er}, {31'd0, eer});
        check({tag, ".lat"}, 32'(lat), 32'(elat));
    endtask

    task automatic run_const(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input string tag,
                             input logic [31:0] xrd, input logic xer, input int xlat);
        logic [31:0] rd, mrd;
        logic er, mer;
        int lat, mlat;
        model(we, f3, addr, wd, mrd, mer, mlat);
        issue(we, f3, addr, wd, rd, er, lat);
        check({tag, ".rdata"}, rd, xrd);
        check({tag, ".err"}, {31'd0, er}, {31'd0, xer});
        check({tag, ".lat"}, 32'(lat), 32'(xlat));
    endtask

    initial begin
        logic [31:0] erd;
        logic eer;
        int elat;
        logic [31:0] addr;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.ready", {31'd0, req_ready}, 32'd0);
        check("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst.rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst.rsp_rdata", rsp_rdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst.ready_after", {31'd0, req_ready}, 32'd1);

        for (int w = 0; w <= 16; w++) run(1'b1, 3'b010, 32'(w * 4), $urandom(), "init");
        run(1'b1, 3'b010, 32'((DEPTH - 2) * 4), $urandom(), "init_top");
        run(1'b1, 3'b010, 32'((DEPTH - 1) * 4), $urandom(), "init_top");

        run_const(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, "sw_10", 32'd0, 1'b0, 1);
        run_const(1'b0, 3'b010, 32'h10, 32'd0, "lw_10", 32'hDEAD_BEEF, 1'b0, 1);
        run_const(1'b1, 3'b000, 32'h11, 32'hAAAA_AA7F, "sb_11", 32'd0, 1'b0, 1);
        run_const(1'b0, 3'b010, 32'h10, 32'd0, "lw_10_after_sb", 32'hDEAD_7FEF, 1'b0, 1);
        run_const(1'b0, 3'b000, 32'h13, 32'd0, "lb_13", 32'hFFFF_FFDE, 1'b0, 1);
        run_const(1'b0, 3'b100, 32'h13, 32'd0, "lbu_13", 32'h0000_00DE, 1'b0, 1);
        run_const(1'b0, 3'b001, 32'h12, 32'd0, "lh_12", 32'hFFFF_DEAD, 1'b0, 1);
        run_const(1'b0, 3'b101, 32'h12, 32'd0, "lhu_12", 32'h0000_DEAD, 1'b0, 1);

        run(1'b1, 3'b010, 32'h0E, 32'h1122_3344, "sw_0e");
        run(1'b0, 3'b010, 32'h0C, 32'd0, "lw_0c");
        run(1'b0, 3'b010, 32'h10, 32'd0, "lw_10_post_split");
        run(1'b0, 3'b001, 32'h11, 32'd0, "lh_11");

        run_const(1'b1, 3'b010, 32'h800, 32'h1234_5678, "sw_oor", 32'd0, 1'b1, 1);
        run_const(1'b0, 3'b011, 32'h10, 32'd0, "ld_f3_011", 32'd0, 1'b1, 1);
        run_const(1'b1, 3'b100, 32'h10, 32'hFFFF_FFFF, "st_f3_100", 32'd0, 1'b1, 1);
        run(1'b0, 3'b010, 32'h10, 32'd0, "lw_10_after_errs");
        run(1'b0, 3'b010, 32'((DEPTH - 1) * 4), 32'd0, "lw_last");
        run(1'b0, 3'b001, 32'(DEPTH * 4 - 1), 32'd0, "lh_top_edge");
        run(1'b1, 3'b000, 32'(DEPTH * 4), 32'h55, "sb_past_end");

        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h20; req_wdata = 32'hCAFE_F00D;
        model(1'b1, 3'b010, 32'h20, 32'hCAFE_F00D, erd, eer, elat);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("rst_in_resp.valid_before", {31'd0, rsp_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_in_resp.valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_in_resp.ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_resp.ready_after", {31'd0, req_ready}, 32'd1);
        run(1'b0, 3'b010, 32'h20, 32'd0, "lw_20_retained");
        run(1'b0, 3'b010, 32'h10, 32'd0, "lw_10_retained");

`ifdef DMEM_MISALIGN_SPLIT_EN
        run(1'b1, 3'b010, 32'h0C, 32'hA0A1_A2A3, "pre_split_0c");
        run(1'b1, 3'b010, 32'h10, 32'hB0B1_B2B3, "pre_split_10");
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h0E; req_wdata = 32'h1122_3344;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("split_rst.valid_in_second", {31'd0, rsp_valid}, 32'd0);
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("split_rst.valid_in_reset", {31'd0, rsp_valid}, 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("split_rst.ready_after", {31'd0, req_ready}, 32'd1);
        mdl[32'h0E] = 8'h44;
        mdl[32'h0F] = 8'h33;
        run(1'b0, 3'b010, 32'h0C, 32'd0, "split_rst.lw_0c");
        run(1'b0, 3'b010, 32'h10, 32'd0, "split_rst.lw_10");
`endif

        model(1'b0, 3'b010, 32'h10, 32'd0, erd, eer, elat);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
        for (int i = 0; i < 10; i++) begin
            check("thru.ready", {31'd0, req_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check("thru.rsp_valid", {31'd0, rsp_valid}, (i % 2 == 1) ? 32'd1 : 32'd0);
            if (i % 2 == 1) check("thru.rdata", rsp_rdata, erd);
            @(negedge clk);
        end
        req_valid = 1'b0;

        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 9))
                0, 1:    addr = 32'(DEPTH * 4 - 8) + $urandom_range(0, 15);
                2:       addr = $urandom() | 32'h8000_0000;
                default: addr = $urandom_range(0, 63);
            endcase
            run(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), addr, $urandom(), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/byte_lane_dmem.md
BYTE_LANE_DMEM -- requirements
Module: byte_lane_dmem

Interface
REQ-001 Parameter DEPTH, default 512, memory size in 32-bit words (power of two, 2..65536).
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  block can accept a request.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I load/store width/sign code.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, LSB-aligned (sb uses [7:0], sh uses [15:0]).
REQ-010 rsp_valid  output  1  one-cycle response pulse.
REQ-011 rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-012 rsp_err  output  1  request rejected; valid only with rsp_valid.

Function
REQ-013 Handshake: request accepted on a posedge with req_valid=1 and req_ready=1; one request outstanding at a time.
REQ-014 FSM states: IDLE, SECOND, RESP. req_ready=1 only in IDLE.
REQ-015 Transitions: IDLE->RESP on a non-crossing or error accept; IDLE->SECOND on a word-crossing accept; SECOND->RESP; RESP->IDLE. Without accept, IDLE holds.
REQ-016 rsp_valid=1 for exactly the RESP cycle: 1 cycle after accept for single access, 2 cycles after for a split access; no response back-pressure.
REQ-017 Loads: 000 lb sign-extend, 001 lh sign-extend, 010 lw, 100 lbu zero-extend, 101 lhu zero-extend; any other code -> rsp_err=1.
REQ-018 Stores: 000 sb, 001 sh, 010 sw; any other code -> rsp_err=1, memory unchanged.
REQ-019 Stores write only the addressed byte lanes (little-endian); other bytes of the word keep their value.
REQ-020 Store write occurs at the accept edge (first word) and, for splits, at the SECOND edge (second word).
REQ-021 A load accepted immediately after a store returns the stored data (no stale read).
REQ-022 Word index = req_addr[31:2]; if any touched word index >= DEPTH -> rsp_err=1, no bytes written (checked at accept, before any write).
REQ-023 Word-crossing: byte offset req_addr[1:0] plus access size (1/2/4) exceeds 4.
REQ-024 Error responses have rsp_rdata=0; errors never modify memory.

Reset
REQ-025 While rst_n=0: state=IDLE, req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0; req_ready=1 from the first clock after release.
REQ-026 Memory array is not reset; contents are retained across reset.
REQ-027 Reset during SECOND abandons the access: the second-word write of a split store is not performed and no response is issued.

Configuration
REQ-028 Macro DMEM_MISALIGN_SPLIT_EN defined: misaligned non-crossing accesses complete in one access; word-crossing accesses are split across two words via SECOND.
REQ-029 Macro undefined: any access not naturally aligned (half with addr[0]=1, word with addr[1:0]!=0) -> rsp_err=1 at 1-cycle latency; SECOND is unreachable.

Verification
REQ-030 sw 0xDEADBEEF @0x10, then lw @0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 1 cycle after each accept.
REQ-031 After REQ-030: sb 0x7F @0x11, then lw @0x10 -> 0xDEAD7FEF; lb @0x13 -> 0xFFFFFFDE; lbu @0x13 -> 0x000000DE.
REQ-032 With DMEM_MISALIGN_SPLIT_EN: sw 0x11223344 @0x0E -> rsp at +2 cycles; lw @0x0C -> 0x3344xxxx (upper half), lw @0x10 -> upper bytes unchanged, low half 0x1122; without macro -> rsp_err=1, memory unchanged.
REQ-033 DEPTH=512: sw @0x800 -> rsp_err=1, rsp_rdata=0; load funct3=011 -> rsp_err=1.
REQ-034 Split store @0x0E, rst_n pulsed low during SECOND -> no rsp_valid; word 0x10 unchanged, word 0x0C holds new bytes; req_ready=1 one clock after release.
REQ-035 req_valid held high continuously with aligned requests -> one accept every 2 cycles, req_ready=0 in RESP cycles.
